// File: rtl/chk_pkg.sv
// Shared types and helpers for the stream tolerance checker: FSM state
// encoding, wrap-around lane comparison and mismatch population count.
package chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } chk_state_e;

  localparam int unsigned MAX_W     = 32;
  localparam int unsigned MAX_LANES = 64;

  // d = (act - exp) mod 2^w; a lane matches when d lies in [-tol, +tol] around zero.
  function automatic logic lane_match(input logic [63:0] act,
                                      input logic [63:0] exp,
                                      input logic [63:0] tol,
                                      input int unsigned w);
    logic [63:0] modv;
    logic [63:0] d;
    modv = 64'd1 << w;
    d    = (act - exp) & (modv - 64'd1);
    return (d <= tol) || (d >= (modv - tol));
  endfunction

  function automatic logic [7:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      n = n + 8'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/chk_fifo.sv
// Synchronous FIFO for golden beats; count-based full/empty, pointers wrap
// modulo DEPTH (DEPTH must be a power of two). Push when full and pop when
// empty are ignored.
module chk_fifo #(
  parameter int DW    = 256,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full    = (cnt == (AW+1)'(DEPTH));
    empty   = (cnt == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rdata   = mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/stream_tol_checker.sv
// Stream scoreboard: queues golden beats, compares each DUT beat lane-wise
// within a +/-TOL wrap-around window, counts mismatches and reports a verdict.
module stream_tol_checker
  import chk_pkg::*;
#(
  parameter int W          = 16,
  parameter int LANES      = 16,
  parameter int TOL        = 3,
  parameter int DEPTH      = 16,
  parameter int FAIL_LIMIT = 48,
  parameter int CNTW       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exp_valid,
  output logic               exp_ready,
  input  logic [LANES*W-1:0] exp_data,
  input  logic               act_valid,
  input  logic               act_last,
  input  logic [LANES*W-1:0] act_data,
  output logic               mism_valid,
  output logic [LANES-1:0]   mism_mask,
  output logic [CNTW-1:0]    err_cnt,
  output logic [CNTW-1:0]    beat_cnt,
  output logic               underflow,
  output logic               abort,
  output logic               done,
  output logic               pass
);

  chk_state_e state, state_nx;

  logic               fifo_full;
  logic               fifo_empty;
  logic [LANES*W-1:0] fifo_rdata;
  logic               push;
  logic               accept;
  logic               pop;
  logic               uflow_evt;
  logic [LANES-1:0]   lane_mism;

  // Stage 1: per-lane mismatch registered at the accepting edge
  logic               s1_valid;
  logic [LANES-1:0]   s1_mask;
  logic               s1_last;
  // Stage 2: last-beat flag aligned with the updated counters
  logic               m_last;

  logic [MAX_LANES-1:0] mask_ext;
  logic [7:0]           mask_pop;
  logic [CNTW:0]        err_sum;
  logic [CNTW-1:0]      err_next;
  logic [CNTW-1:0]      beat_next;
  logic                 limit_hit;

  chk_fifo #(
    .DW    (LANES*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (exp_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    push      = exp_valid && !fifo_full;
    accept    = act_valid && ((state == IDLE) || (state == RUN));
    pop       = accept && !fifo_empty;
    uflow_evt = accept && fifo_empty;
  end

  always_comb begin
    lane_mism = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_mism[i] = !lane_match(64'(act_data[i*W +: W]),
                                 64'(fifo_rdata[i*W +: W]),
                                 64'(TOL), W);
    end
  end

  always_comb begin
    mask_ext               = '0;
    mask_ext[LANES-1:0]    = s1_mask;
    mask_pop               = popcount(mask_ext);
    err_sum                = {1'b0, err_cnt} + (CNTW+1)'(mask_pop);
    err_next               = err_sum[CNTW] ? '1 : err_sum[CNTW-1:0];
    beat_next              = (beat_cnt == '1) ? beat_cnt : beat_cnt + CNTW'(1);
    limit_hit              = (err_cnt >= CNTW'(FAIL_LIMIT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_mask   <= '0;
      s1_last   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      s1_valid <= pop;
      s1_mask  <= pop ? lane_mism : '0;
      s1_last  <= accept && act_last;
      if (uflow_evt) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mism_valid <= 1'b0;
      mism_mask  <= '0;
      err_cnt    <= '0;
      beat_cnt   <= '0;
      m_last     <= 1'b0;
    end else begin
      mism_valid <= s1_valid;
      m_last     <= s1_last;
      if (s1_valid) begin
        mism_mask <= s1_mask;
        err_cnt   <= err_next;
        beat_cnt  <= beat_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // The limit check reads the registered count, so ABORT lands one cycle
  // after the counter and wins over a simultaneous last beat.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (act_valid) state_nx = RUN;
      RUN: begin
        if (limit_hit)   state_nx = ABORT;
        else if (m_last) state_nx = DONE;
      end
      DONE:    state_nx = DONE;
      ABORT:   state_nx = ABORT;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    exp_ready = !fifo_full;
    abort     = (state == ABORT);
    done      = (state == DONE) || (state == ABORT);
    pass      = done && (err_cnt == '0) && !underflow && !abort;
  end

endmodule

// File: tb/tb_stream_tol_checker.sv
// Scoreboard bench for stream_tol_checker: stimulus queues expected compare
// results, a negedge monitor pops and checks them when mism_valid pulses.
module tb_stream_tol_checker;

  localparam int W          = 16;
  localparam int LANES      = 16;
  localparam int TOL        = 3;
  localparam int DEPTH      = 4;
  localparam int FAIL_LIMIT = 48;
  localparam int CNTW       = 16;
  localparam int DW         = W*LANES;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            exp_valid = 1'b0;
  logic            exp_ready;
  logic [DW-1:0]   exp_data = '0;
  logic            act_valid = 1'b0;
  logic            act_last = 1'b0;
  logic [DW-1:0]   act_data = '0;
  logic            mism_valid;
  logic [LANES-1:0] mism_mask;
  logic [CNTW-1:0] err_cnt;
  logic [CNTW-1:0] beat_cnt;
  logic            underflow;
  logic            abort;
  logic            done;
  logic            pass;

  stream_tol_checker #(
    .W          (W),
    .LANES      (LANES),
    .TOL        (TOL),
    .DEPTH      (DEPTH),
    .FAIL_LIMIT (FAIL_LIMIT),
    .CNTW       (CNTW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .exp_valid  (exp_valid),
    .exp_ready  (exp_ready),
    .exp_data   (exp_data),
    .act_valid  (act_valid),
    .act_last   (act_last),
    .act_data   (act_data),
    .mism_valid (mism_valid),
    .mism_mask  (mism_mask),
    .err_cnt    (err_cnt),
    .beat_cnt   (beat_cnt),
    .underflow  (underflow),
    .abort      (abort),
    .done       (done),
    .pass       (pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0] mask;
    int               err;
    int               beats;
  } sb_t;

  sb_t q[$];
  int  n_pass  = 0;
  int  n_total = 0;
  int  m_err   = 0;
  int  m_beats = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    n_total++;
    if (got === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, got, req, $time);
  endtask

  always @(negedge clk) begin
    if (rst && mism_valid) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL mism_unexpected: got mism_valid=1, required no pending compare at %0t", $time);
      end else begin
        sb_t e;
        e = q.pop_front();
        chk("sb_mask", 64'(mism_mask), 64'(e.mask));
        chk("sb_err_cnt", 64'(err_cnt), 64'(e.err));
        chk("sb_beat_cnt", 64'(beat_cnt), 64'(e.beats));
      end
    end
  end

  // One cycle of stimulus; a compared beat queues its expected result first.
  task automatic drive(input logic dp, input logic [DW-1:0] ed,
                       input logic da, input logic [DW-1:0] ad,
                       input logic last, input logic cmp,
                       input logic [LANES-1:0] mask);
    if (cmp) begin
      sb_t e;
      m_err   += $countones(mask);
      m_beats += 1;
      e.mask  = mask;
      e.err   = m_err;
      e.beats = m_beats;
      q.push_back(e);
    end
    exp_valid = dp;
    exp_data  = ed;
    act_valid = da;
    act_data  = ad;
    act_last  = last;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    act_valid = 1'b0;
    act_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    exp_valid = 1'b0;
    act_valid = 1'b0;
    act_last  = 1'b0;
    q.delete();
    m_err   = 0;
    m_beats = 0;
    #2;
    chk("rst_exp_ready", 64'(exp_ready), 64'd1);
    chk("rst_mism_valid", 64'(mism_valid), 64'd0);
    chk("rst_mism_mask", 64'(mism_mask), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    chk("rst_underflow", 64'(underflow), 64'd0);
    chk("rst_abort", 64'(abort), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*W +: W] = W'($urandom);
    return v;
  endfunction

  logic [W-1:0] we_exp [4] = '{16'h0000, 16'h0000, 16'h7FFE, 16'h7FFE};
  logic [W-1:0] we_act [4] = '{16'hFFFD, 16'hFFFC, 16'h8001, 16'h8002};
  logic         we_mis [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish within 200000 time units");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] ed, ad;
    logic [DW-1:0] dq [8];
    logic [W-1:0]  e;

    do_reset();

    // Exact stream, 64 beats
    for (int b = 0; b < 64; b++) begin
      ed = rand_beat();
      drive(1'b1, ed, 1'b0, '0, 1'b0, 1'b0, '0);
      drive(1'b0, '0, 1'b1, ed, (b == 63), 1'b1, '0);
    end
    chk("exact_done_t0", 64'(done), 64'd0);
    idle(1);
    chk("exact_done_t1", 64'(done), 64'd0);
    idle(1);
    chk("exact_done_t2", 64'(done), 64'd1);
    chk("exact_pass", 64'(pass), 64'd1);
    chk("exact_err", 64'(err_cnt), 64'd0);
    chk("exact_beats", 64'(beat_cnt), 64'd64);

    // Window edges on lane 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ed = '0;
      ad = '0;
      ed[W-1:0] = we_exp[i];
      ad[W-1:0] = we_act[i];
      drive(1'b1, ed, 1'b0, '0, 1'b0, 1'b0, '0);
      drive(1'b0, '0, 1'b1, ad, (i == 3), 1'b1, {{(LANES-1){1'b0}}, we_mis[i]});
      if (i == 0) begin
        chk("lat_mism_t0", 64'(mism_valid), 64'd0);
        idle(1);
        chk("lat_mism_t1", 64'(mism_valid), 64'd1);
      end
    end
    idle(2);
    chk("edge_err", 64'(err_cnt), 64'd2);
    chk("edge_done", 64'(done), 64'd1);
    chk("edge_pass", 64'(pass), 64'd0);

    // Fail limit: 3 beats, every lane off by +4
    do_reset();
    for (int b = 0; b < 3; b++) begin
      for (int l = 0; l < LANES; l++) begin
        e = 16'hFFFE - 16'(l*257) - 16'(b);
        ed[l*W +: W] = e;
        ad[l*W +: W] = e + 16'd4;
      end
      drive(1'b1, ed, 1'b0, '0, 1'b0, 1'b0, '0);
      drive(1'b0, '0, 1'b1, ad, 1'b0, 1'b1, '1);
    end
    chk("abort_t0", 64'(abort), 64'd0);
    idle(1);
    chk("abort_err_t1", 64'(err_cnt), 64'd48);
    chk("abort_t1", 64'(abort), 64'd0);
    idle(1);
    chk("abort_t2", 64'(abort), 64'd1);
    chk("abort_done", 64'(done), 64'd1);
    chk("abort_pass", 64'(pass), 64'd0);
    drive(1'b1, ed, 1'b1, ad, 1'b1, 1'b0, '0);
    idle(3);
    chk("abort_err_hold", 64'(err_cnt), 64'd48);
    chk("abort_beats_hold", 64'(beat_cnt), 64'd3);
    chk("abort_ready", 64'(exp_ready), 64'd1);
    for (int k = 0; k < 3; k++) drive(1'b1, ed, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("abort_fifo_full", 64'(exp_ready), 64'd0);

    // Underflowing last beat still finishes the run
    do_reset();
    drive(1'b0, '0, 1'b1, rand_beat(), 1'b1, 1'b0, '0);
    idle(2);
    chk("uflast_done", 64'(done), 64'd1);
    chk("uflast_pass", 64'(pass), 64'd0);
    chk("uflast_beats", 64'(beat_cnt), 64'd0);

    // Underflow, then same-cycle push + act on empty FIFO
    do_reset();
    drive(1'b0, '0, 1'b1, rand_beat(), 1'b0, 1'b0, '0);
    chk("uf_flag", 64'(underflow), 64'd1);
    idle(2);
    chk("uf_beats", 64'(beat_cnt), 64'd0);
    ed = rand_beat();
    drive(1'b1, ed, 1'b1, rand_beat(), 1'b0, 1'b0, '0);
    ad = ed;
    ad[3*W +: W] = ed[3*W +: W] + 16'd5;
    drive(1'b0, '0, 1'b1, ad, 1'b1, 1'b1, 16'h0008);
    idle(2);
    chk("uf_done", 64'(done), 64'd1);
    chk("uf_pass", 64'(pass), 64'd0);
    chk("uf_beats_after", 64'(beat_cnt), 64'd1);

    // Full FIFO and ordering across simultaneous push/pop
    do_reset();
    for (int k = 0; k < 8; k++)
      for (int l = 0; l < LANES; l++) dq[k][l*W +: W] = 16'(k*16'h1000 + l*16'h0011 + 1);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, dq[k], 1'b0, '0, 1'b0, 1'b0, '0);
      chk($sformatf("full_ready_%0d", k), 64'(exp_ready), (k < 3) ? 64'd1 : 64'd0);
    end
    drive(1'b0, '0, 1'b1, dq[0], 1'b0, 1'b1, '0);
    chk("full_ready_pop", 64'(exp_ready), 64'd1);
    drive(1'b1, dq[6], 1'b1, dq[1], 1'b0, 1'b1, '0);
    chk("full_ready_pushpop", 64'(exp_ready), 64'd1);
    drive(1'b1, dq[7], 1'b0, '0, 1'b0, 1'b0, '0);
    chk("full_ready_refill", 64'(exp_ready), 64'd0);
    drive(1'b0, '0, 1'b1, dq[2], 1'b0, 1'b1, '0);
    drive(1'b0, '0, 1'b1, dq[3], 1'b0, 1'b1, '0);
    drive(1'b0, '0, 1'b1, dq[6], 1'b0, 1'b1, '0);
    drive(1'b0, '0, 1'b1, dq[7], 1'b1, 1'b1, '0);
    idle(2);
    chk("full_pass", 64'(pass), 64'd1);
    chk("full_beats", 64'(beat_cnt), 64'd6);

    // Mid-stream reset with a stale beat left queued
    do_reset();
    for (int b = 0; b < 10; b++) begin
      ed = rand_beat();
      ad = ed;
      if (b % 2 == 0) ad[W-1:0] = ed[W-1:0] + 16'd10;
      drive(1'b1, ed, 1'b0, '0, 1'b0, 1'b0, '0);
      drive(1'b0, '0, 1'b1, ad, 1'b0, 1'b1, (b % 2 == 0) ? 16'h0001 : 16'h0000);
    end
    idle(2);
    chk("mid_err", 64'(err_cnt), 64'd5);
    chk("mid_beats", 64'(beat_cnt), 64'd10);
    drive(1'b1, {LANES{16'hAAAA}}, 1'b0, '0, 1'b0, 1'b0, '0);
    do_reset();
    for (int b = 0; b < 4; b++) begin
      ed = rand_beat();
      drive(1'b1, ed, 1'b0, '0, 1'b0, 1'b0, '0);
      drive(1'b0, '0, 1'b1, ed, (b == 3), 1'b1, '0);
    end
    idle(2);
    chk("fresh_done", 64'(done), 64'd1);
    chk("fresh_pass", 64'(pass), 64'd1);
    chk("fresh_beats", 64'(beat_cnt), 64'd4);

    idle(2);
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
